ram_dump_tx: RTL

Read-back path for the simple CPU's 16×8 program RAM. Program bytes enter the RAM through the logic-analyzer load port; this block carries them back out of the chip. On a start strobe it reads a contiguous, wrap-around address range from the RAM read port. It then transmits each byte as a UART 8N1 frame on one user I/O pad, so the host can verify a loaded program or dump a halted machine's memory.

---
 rtl/simplecpu_pkg.sv | 19 +
 rtl/uart_tx_frame.sv | 86 ++++++++
 rtl/ram_dump_tx.sv | 112 +++++++++++
 3 files changed

// File: rtl/simplecpu_pkg.sv
// Shared constants for the simple CPU: RAM geometry, UART frame shape and the
// read-back sequencer state encoding.
package simplecpu_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  localparam logic FRAME_START_BIT = 1'b0;
  localparam logic FRAME_STOP_BIT  = 1'b1;
  localparam int   FRAME_DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;

endpackage

// File: rtl/uart_tx_frame.sv
// One 8N1 frame serializer: start bit, DATA_W bits LSB first, stop bit.
// frame_done is high during the final cycle of the stop bit.
module uart_tx_frame
  import simplecpu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              tx,
  output logic              frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  logic [2:0]        phase_q, phase_d;
  logic [CW-1:0]     baud_q, baud_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              tick;

  assign tick       = (baud_q == BAUD_LAST);
  assign frame_done = (phase_q == ST_STOP) && tick;
  assign tx         = tx_q;

  always_comb begin
    phase_d = phase_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (load) begin
      phase_d = ST_START;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = data;
      tx_d    = FRAME_START_BIT;
    end else if (phase_q != ST_IDLE) begin
      baud_d = tick ? '0 : baud_q + 1'b1;
      if (tick) begin
        case (phase_q)
          ST_START: begin
            phase_d = ST_DATA;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
          ST_DATA: begin
            if (bit_q == BIT_LAST) begin
              phase_d = ST_STOP;
              tx_d    = FRAME_STOP_BIT;
            end else begin
              bit_d   = bit_q + 1'b1;
              tx_d    = shift_q[0];
              shift_d = shift_q >> 1;
            end
          end
          default: phase_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      phase_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= FRAME_STOP_BIT;
    end else begin
      phase_q <= phase_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/ram_dump_tx.sv
// Program RAM read-back: walks a wrap-around address range, fetches each byte
// and sends it out as a UART 8N1 frame.
module ram_dump_tx
  import simplecpu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_W       = simplecpu_pkg::ADDR_W,
  parameter int DATA_W       = simplecpu_pkg::DATA_W
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] first_addr_i,
  input  logic [ADDR_W-1:0] last_addr_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [4:0]        byte_cnt_o
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_q, rd_d;
  logic              frame_done;

  // The serializer owns the START/DATA/STOP bit timing; the sequencer parks in
  // ST_START until it reports the end of the stop bit.
  uart_tx_frame #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_W      (DATA_W)
  ) u_frame (
    .clk       (wb_clk_i),
    .srst      (wb_rst_i),
    .load      (state_q == ST_WAIT),
    .data      (mem_data_i),
    .tx        (tx_o),
    .frame_done(frame_done)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rd_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d  = first_addr_i;
          last_d  = last_addr_i;
          cnt_d   = '0;
          busy_d  = 1'b1;
          rd_d    = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_START;
      ST_START: begin
        if (frame_done) begin
          cnt_d = cnt_q + 1'b1;
          if (addr_q == last_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            addr_d  = addr_q + 1'b1;
            rd_d    = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
    end
  end

  assign mem_rd_o   = rd_q;
  assign mem_addr_o = addr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign byte_cnt_o = cnt_q;

endmodule
